// File: rtl/rain_guard_pkg.sv
// rtl/rain_guard_pkg.sv - shared slew-state encoding, default servo timing and step helper
package rain_guard_pkg;

  typedef enum logic [1:0] {
    HOLD      = 2'b00,
    RAMP_UP   = 2'b01,
    RAMP_DOWN = 2'b10
  } slew_state_t;

  // 50 MHz clock: 20 ms frame, 1 ms open, 1.5 ms closed, 50 us slew per frame
  localparam int DEF_PERIOD_CYC  = 1000000;
  localparam int DEF_PULSE_OPEN  = 50000;
  localparam int DEF_PULSE_CLOSE = 75000;
  localparam int DEF_STEP        = 2500;

  // Move cur toward tgt by at most step without passing it; comparing the
  // distance instead of cur+step keeps the arithmetic free of wrap-around.
  function automatic logic [31:0] step_toward(input logic [31:0] cur,
                                              input logic [31:0] tgt,
                                              input logic [31:0] step);
    logic [31:0] res;
    res = cur;
    if (cur < tgt) begin
      res = ((tgt - cur) > step) ? cur + step : tgt;
    end else if (cur > tgt) begin
      res = ((cur - tgt) > step) ? cur - step : tgt;
    end
    return res;
  endfunction

endpackage

// File: rtl/servo_pwm_driver_if.sv
// rtl/servo_pwm_driver_if.sv - position select and pulse/status signals of the servo driver
interface servo_pwm_driver_if;
  import rain_guard_pkg::*;

  logic        angle_sel;
  logic        pwm_out;
  logic        frame_start;
  logic        busy;
  slew_state_t slew_state;

  modport master (
    output angle_sel,
    input  pwm_out,
    input  frame_start,
    input  busy,
    input  slew_state
  );

  modport slave (
    input  angle_sel,
    output pwm_out,
    output frame_start,
    output busy,
    output slew_state
  );

endinterface

// File: rtl/pwm_frame_counter.sv
// rtl/pwm_frame_counter.sv - free-running PWM frame counter with wrap flag
module pwm_frame_counter
  import rain_guard_pkg::*;
#(
  parameter int PERIOD_CYC = DEF_PERIOD_CYC,
  parameter int W          = $clog2(PERIOD_CYC)
) (
  input  logic         clk,
  input  logic         reset,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(PERIOD_CYC - 1);

  // wrap marks the last cycle of a frame; the following edge starts a new one
  assign wrap = (cnt == LAST);

  // Count 0..PERIOD_CYC-1; reset parks on the last count so release opens a frame
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= LAST;
    end else if (wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/servo_pwm_driver.sv
// rtl/servo_pwm_driver.sv - slew-limited servo PWM generator with frame-aligned updates
module servo_pwm_driver
  import rain_guard_pkg::*;
#(
  parameter int PERIOD_CYC  = DEF_PERIOD_CYC,
  parameter int PULSE_OPEN  = DEF_PULSE_OPEN,
  parameter int PULSE_CLOSE = DEF_PULSE_CLOSE,
  parameter int STEP        = DEF_STEP
) (
  input  logic                 clk,
  input  logic                 reset,
  servo_pwm_driver_if.slave    bus
);

  localparam int W = $clog2(PERIOD_CYC);
  localparam logic [W-1:0] OPEN_W  = W'(PULSE_OPEN);
  localparam logic [W-1:0] CLOSE_W = W'(PULSE_CLOSE);

  if (!(PULSE_OPEN > 0 && PULSE_OPEN < PULSE_CLOSE &&
        PULSE_CLOSE < PERIOD_CYC && STEP >= 1)) begin : g_bad_params
    $error("servo_pwm_driver: illegal timing parameters");
  end

  logic [W-1:0] cnt;
  logic         wrap;
  logic [W-1:0] cnt_next;
  logic [W-1:0] target_width;
  logic [W-1:0] target_next;
  logic [W-1:0] active_width;
  logic [W-1:0] active_next;
  slew_state_t  state;
  slew_state_t  state_next;
  logic         pwm_q;
  logic         frame_start_q;

  pwm_frame_counter #(
    .PERIOD_CYC (PERIOD_CYC),
    .W          (W)
  ) u_frame_counter (
    .clk   (clk),
    .reset (reset),
    .cnt   (cnt),
    .wrap  (wrap)
  );

  // Widths and slew state only move on the wrap edge, so a frame never changes shape
  always_comb begin
    cnt_next    = wrap ? '0 : cnt + W'(1);
    target_next = target_width;
    active_next = active_width;
    state_next  = state;
    if (wrap) begin
      target_next = bus.angle_sel ? CLOSE_W : OPEN_W;
      active_next = W'(step_toward(32'(active_width), 32'(target_next), 32'(STEP)));
      if (active_next < target_next) begin
        state_next = RAMP_UP;
      end else if (active_next > target_next) begin
        state_next = RAMP_DOWN;
      end else begin
        state_next = HOLD;
      end
    end
  end

  // Slew FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= HOLD;
    end else begin
      state <= state_next;
    end
  end

  // Width registers and output flops; pwm is precomputed for the upcoming count
  always_ff @(posedge clk) begin
    if (reset) begin
      target_width  <= OPEN_W;
      active_width  <= OPEN_W;
      pwm_q         <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      target_width  <= target_next;
      active_width  <= active_next;
      pwm_q         <= (cnt_next < active_next);
      frame_start_q <= wrap;
    end
  end

  assign bus.pwm_out     = pwm_q;
  assign bus.frame_start = frame_start_q;
  assign bus.slew_state  = state;
  assign bus.busy        = (state != HOLD);

endmodule

// File: tb/tb_servo_pwm_driver.sv
// tb/tb_servo_pwm_driver.sv - frame-level directed checks of servo_pwm_driver
module tb_servo_pwm_driver;
  import rain_guard_pkg::*;

  localparam int PERIOD = 100;
  localparam int OPEN   = 10;
  localparam int CLOSE  = 22;
  localparam int STEP   = 5;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  servo_pwm_driver_if bus();

  servo_pwm_driver #(
    .PERIOD_CYC  (PERIOD),
    .PULSE_OPEN  (OPEN),
    .PULSE_CLOSE (CLOSE),
    .STEP        (STEP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic sel;
    int   width;
    int   busy;
    int   state;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Starts at the negedge of the last cycle of a frame, ends at the next one.
  // angle_sel = sel at the wrap edge; for counts lo..hi it is gval instead.
  task automatic run_frame(input logic sel, input int lo, input int hi, input logic gval,
                           output int width, output int fs_total, output int fs_first,
                           output int rerise, output int st, output int bz);
    logic prev;
    bus.angle_sel = sel;
    width = 0; fs_total = 0; fs_first = 0; rerise = 0; st = 0; bz = 0;
    prev = 1'b1;
    for (int i = 0; i < PERIOD; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.pwm_out) width++;
      if (bus.pwm_out && !prev) rerise++;
      prev = bus.pwm_out;
      if (bus.frame_start) fs_total++;
      if (i == 0) begin
        fs_first = int'(bus.frame_start);
        st       = int'(bus.slew_state);
        bz       = int'(bus.busy);
      end
      if (i < PERIOD - 1) bus.angle_sel = (i + 1 >= lo && i + 1 <= hi) ? gval : sel;
    end
  endtask

  task automatic frame_check(input string tag, input logic sel, input int lo, input int hi,
                             input logic gval, input int exp_w, input int exp_busy,
                             input int exp_st);
    int w, fst, fsf, rr, st, bz;
    run_frame(sel, lo, hi, gval, w, fst, fsf, rr, st, bz);
    check($sformatf("%s.width", tag), w, exp_w);
    check($sformatf("%s.frame_start_first", tag), fsf, 1);
    check($sformatf("%s.frame_start_count", tag), fst, 1);
    check($sformatf("%s.pwm_shape", tag), rr, 0);
    check($sformatf("%s.busy", tag), bz, exp_busy);
    check($sformatf("%s.slew_state", tag), st, exp_st);
  endtask

  // Caller leaves width at 15 heading closed, so this frame runs at width 20.
  task automatic reset_mid_frame(input string tag, input int at_cnt, input logic sel_after,
                                 input int exp_w);
    int hi;
    int exp_hi;
    hi = 0;
    bus.angle_sel = 1'b1;
    for (int i = 0; i <= at_cnt; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.pwm_out) hi++;
    end
    exp_hi = (at_cnt + 1 < 20) ? at_cnt + 1 : 20;
    check($sformatf("%s.partial_high", tag), hi, exp_hi);
    check($sformatf("%s.pwm_before", tag), int'(bus.pwm_out), (at_cnt < 20) ? 1 : 0);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("%s.rst_pwm%0d", tag, k), int'(bus.pwm_out), 0);
      check($sformatf("%s.rst_fs%0d", tag, k), int'(bus.frame_start), 0);
      check($sformatf("%s.rst_busy%0d", tag, k), int'(bus.busy), 0);
      check($sformatf("%s.rst_state%0d", tag, k), int'(bus.slew_state), int'(HOLD));
    end
    reset = 1'b0;
    frame_check($sformatf("%s.after", tag), sel_after, 1, 0, 1'b0, exp_w,
                sel_after ? 1 : 0, sel_after ? int'(RAMP_UP) : int'(HOLD));
  endtask

  initial begin
    vecs[0]  = '{1'b0, 10, 0, int'(HOLD)};
    vecs[1]  = '{1'b0, 10, 0, int'(HOLD)};
    vecs[2]  = '{1'b0, 10, 0, int'(HOLD)};
    vecs[3]  = '{1'b1, 15, 1, int'(RAMP_UP)};
    vecs[4]  = '{1'b1, 20, 1, int'(RAMP_UP)};
    vecs[5]  = '{1'b1, 22, 0, int'(HOLD)};
    vecs[6]  = '{1'b1, 22, 0, int'(HOLD)};
    vecs[7]  = '{1'b0, 17, 1, int'(RAMP_DOWN)};
    vecs[8]  = '{1'b0, 12, 1, int'(RAMP_DOWN)};
    vecs[9]  = '{1'b0, 10, 0, int'(HOLD)};
    vecs[10] = '{1'b1, 15, 1, int'(RAMP_UP)};
    vecs[11] = '{1'b1, 20, 1, int'(RAMP_UP)};
    vecs[12] = '{1'b0, 15, 1, int'(RAMP_DOWN)};
    vecs[13] = '{1'b0, 10, 0, int'(HOLD)};

    reset = 1'b1;
    bus.angle_sel = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset.pwm_out", int'(bus.pwm_out), 0);
    check("reset.frame_start", int'(bus.frame_start), 0);
    check("reset.busy", int'(bus.busy), 0);
    check("reset.slew_state", int'(bus.slew_state), int'(HOLD));
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      frame_check($sformatf("vec%0d", i), vecs[i].sel, 1, 0, 1'b0,
                  vecs[i].width, vecs[i].busy, vecs[i].state);
    end

    frame_check("glitch", 1'b0, 30, 60, 1'b1, 10, 0, int'(HOLD));
    frame_check("after_glitch", 1'b0, 1, 0, 1'b0, 10, 0, int'(HOLD));

    frame_check("edge_on", 1'b1, 1, 99, 1'b0, 15, 1, int'(RAMP_UP));
    frame_check("edge_off", 1'b0, 1, 99, 1'b1, 10, 0, int'(HOLD));
    frame_check("edge_after", 1'b0, 1, 0, 1'b0, 10, 0, int'(HOLD));

    frame_check("pre_rst37", 1'b1, 1, 0, 1'b0, 15, 1, int'(RAMP_UP));
    reset_mid_frame("rst37", 37, 1'b0, 10);
    frame_check("pre_rst12", 1'b1, 1, 0, 1'b0, 15, 1, int'(RAMP_UP));
    reset_mid_frame("rst12", 12, 1'b1, 15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/servo_pwm_driver.md
SERVO_PWM_DRIVER -- requirements
Module: servo_pwm_driver

Interface
REQ-001 Parameter PERIOD_CYC, default 1000000, sets the PWM frame length in clk cycles (20 ms at 50 MHz).
REQ-002 Parameter PULSE_OPEN, default 50000, sets the high time in cycles for the open position (0 deg, 1 ms).
REQ-003 Parameter PULSE_CLOSE, default 75000, sets the high time in cycles for the closed position (90 deg, 1.5 ms).
REQ-004 Parameter STEP, default 2500, sets the maximum change in high time per frame (slew limit).
REQ-005 Port clk, input, 1, is the single clock; all logic is on its rising edge.
REQ-006 Port reset, input, 1, is a synchronous active-high reset.
REQ-007 Port angle_sel, input, 1, selects the target position: 0 = open, 1 = closed; it is synchronous to clk.
REQ-008 Port pwm_out, output, 1, is the servo control pulse.
REQ-009 Port frame_start, output, 1, is a one-cycle pulse in the first cycle of each frame.
REQ-010 Port busy, output, 1, is 1 while the active width differs from the latched target.
REQ-011 Port slew_state, output, 2, is the current state encoding (HOLD, RAMP_UP, RAMP_DOWN).

Function
REQ-012 Frame counter cnt shall be $clog2(PERIOD_CYC) bits wide, count 0..PERIOD_CYC-1, and wrap to 0.
REQ-013 frame_start shall be 1 exactly in cycles where cnt==0.
REQ-014 angle_sel, target_width and active_width shall be sampled and updated only on the edge where cnt wraps PERIOD_CYC-1 -> 0; angle_sel changes at any other time are ignored.
REQ-015 At that edge, target_width shall be set to PULSE_CLOSE if angle_sel=1 and to PULSE_OPEN otherwise.
REQ-016 At that edge, if active_width < target, then active_width = min(active_width+STEP, target).
REQ-017 At that edge, if active_width > target, then active_width = max(active_width-STEP, target); otherwise active_width is unchanged.
REQ-018 active_width shall be held constant for the whole frame.
REQ-019 pwm_out shall come from a flop and be 1 exactly in cycles where cnt < active_width; it never glitches within a frame.
REQ-020 FSM transitions, evaluated at the frame edge from the new widths: new active<target -> RAMP_UP; new active>target -> RAMP_DOWN; equal -> HOLD.
REQ-021 busy shall be 1 iff slew_state != HOLD.
REQ-022 If target reverses mid-ramp, the next frame shall step from the current active_width toward the new target, with no jump.
REQ-023 If |target-active_width| <= STEP, the target shall be reached in one frame.
REQ-024 Saturating arithmetic shall ensure no overshoot past target and no under/overflow.
REQ-025 Legal parameters are 0 < PULSE_OPEN < PULSE_CLOSE < PERIOD_CYC and STEP >= 1; simulation shall flag other values as an error.

Reset
REQ-026 While reset=1: cnt=PERIOD_CYC-1, active_width=PULSE_OPEN, target_width=PULSE_OPEN, slew_state=HOLD, pwm_out=0, frame_start=0, busy=0.
REQ-027 The first edge after reset deasserts shall wrap cnt to 0 and start a frame that samples angle_sel per REQ-014.
REQ-028 Reset asserted mid-frame or mid-ramp shall abort the frame immediately; no partial pulse shall appear after release.

Structure
REQ-029 The slew_state encoding (HOLD=2'b00, RAMP_UP=2'b01, RAMP_DOWN=2'b10) and the default timing constants shall live in the shared package rain_guard_pkg.
REQ-030 The frame counter shall be a sub-module, pwm_frame_counter (cnt, wrap pulse), instantiated once; slew logic and the FSM shall live in the top module.

Verification (PERIOD_CYC=100, PULSE_OPEN=10, PULSE_CLOSE=22, STEP=5)
REQ-031 Reset, then angle_sel=0 for 3 frames -> pwm_out high 10 cycles per 100, frame_start every 100 cycles, busy=0.
REQ-032 angle_sel=1 held -> frame widths 15, 20, 22, 22; busy=1, 1, 0, 0; slew_state RAMP_UP, RAMP_UP, HOLD.
REQ-033 angle_sel pulsed 1 during cnt=30..60 only, while at open -> widths stay 10, busy stays 0.
REQ-034 Target reverses at width 20 (angle_sel=0 before the next wrap) -> widths 15, 10; slew_state RAMP_DOWN, then HOLD.
REQ-035 Reset asserted at cnt=37 while width=20, held 3 cycles -> pwm_out=0 during reset; the next frame has width 10 (angle_sel=0) or 15 (angle_sel=1).
REQ-036 angle_sel toggled on the exact wrap edge -> the value present at that edge is used; the width changes by at most 5 per frame.
